// File: rtl/commit_trace_buffer_pkg.sv
// Shared definitions for the commit trace buffer.
//   - default parameter values for the trace buffer and its bench
//   - record kind codes (3 bits) and the FSM state encoding
//   - packed trace record for the default configuration
//   - classify_kind(): maps commit strobes to a record kind
package commit_trace_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PC_W   = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 3;
  localparam int DEF_CNT_W  = 32;

  typedef logic [2:0] kind_t;

  localparam kind_t KIND_NOP  = 3'd0;
  localparam kind_t KIND_REG  = 3'd1;
  localparam kind_t KIND_LD   = 3'd2;
  localparam kind_t KIND_ST   = 3'd3;
  localparam kind_t KIND_STU  = 3'd4;
  localparam kind_t KIND_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef struct packed {
    kind_t                  kind;
    logic [DEF_CNT_W-1:0]   inum;
    logic [DEF_CNT_W-1:0]   cycle;
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_REG_W-1:0]   wreg;
    logic [DEF_DATA_W-1:0]  reg_data;
    logic [DEF_PC_W-1:0]    addr;
    logic [DEF_DATA_W-1:0]  mem_data;
  } trace_rec_t;

  // First match wins; a register write outranks halt, so halt+reg_write
  // never produces a HALT record.
  function automatic kind_t classify_kind(input logic reg_write,
                                          input logic mem_read,
                                          input logic mem_write,
                                          input logic halt);
    kind_t k;
    if (reg_write && mem_write) begin
      k = KIND_STU;
    end else if (reg_write && mem_read) begin
      k = KIND_LD;
    end else if (reg_write) begin
      k = KIND_REG;
    end else if (halt) begin
      k = KIND_HALT;
    end else if (mem_write) begin
      k = KIND_ST;
    end else begin
      k = KIND_NOP;
    end
    return k;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Bus interfaces of the commit trace buffer.
//   commit_if : retiring-instruction strobes from the writeback stage.
//               master = core side, slave = trace buffer.
//   trace_if  : valid/ready record stream towards a logger.
//               master = trace buffer, slave = consumer.
interface commit_if #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              commit_valid;
  logic [PC_W-1:0]   commit_pc;
  logic              commit_reg_write;
  logic [REG_W-1:0]  commit_write_reg;
  logic [DATA_W-1:0] commit_write_data;
  logic              commit_mem_read;
  logic              commit_mem_write;
  logic [PC_W-1:0]   commit_mem_addr;
  logic [DATA_W-1:0] commit_mem_data;
  logic              commit_halt;

  modport master (
    output commit_valid, commit_pc, commit_reg_write, commit_write_reg,
           commit_write_data, commit_mem_read, commit_mem_write,
           commit_mem_addr, commit_mem_data, commit_halt
  );

  modport slave (
    input  commit_valid, commit_pc, commit_reg_write, commit_write_reg,
           commit_write_data, commit_mem_read, commit_mem_write,
           commit_mem_addr, commit_mem_data, commit_halt
  );
endinterface

interface trace_if #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
);
  logic              tr_valid;
  logic              tr_ready;
  logic [2:0]        tr_kind;
  logic [CNT_W-1:0]  tr_inum;
  logic [CNT_W-1:0]  tr_cycle;
  logic [PC_W-1:0]   tr_pc;
  logic [REG_W-1:0]  tr_reg;
  logic [DATA_W-1:0] tr_reg_data;
  logic [PC_W-1:0]   tr_addr;
  logic [DATA_W-1:0] tr_mem_data;

  modport master (
    output tr_valid, tr_kind, tr_inum, tr_cycle, tr_pc, tr_reg,
           tr_reg_data, tr_addr, tr_mem_data,
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_kind, tr_inum, tr_cycle, tr_pc, tr_reg,
           tr_reg_data, tr_addr, tr_mem_data,
    output tr_ready
  );
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo: synchronous FIFO, DEPTH a power of two (>= 2).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request; accepted when not full, or when full
//                   and a pop happens in the same cycle
//   pop_i         : read request; ignored when empty
//   rdata_o       : head entry, forced to 0 while empty
//   full_o/empty_o: occupancy flags
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en_s = pop_i && !empty_o;
  // When full, the write slot equals the head slot being popped this cycle.
  assign wr_en_s = push_i && (!full_o || rd_en_s);

  // Pointer next-state.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (rd_en_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents need no reset because empty masks the output.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Head read; no write bypass, so a new entry shows up one cycle later.
  always_comb begin
    rdata_o = '0;
    if (empty_o) begin
      rdata_o = '0;
    end else begin
      rdata_o = mem_q[rd_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures one record per retiring instruction,
// buffers it in a FIFO and streams it out on a valid/ready port.
//   clk_i, rst_ni  : core clock, asynchronous active-low reset
//   commit_bus     : commit strobes from writeback (commit_if.slave)
//   trace_bus      : record stream (trace_if.master)
//   inst_count_o   : commits seen (frozen once halted)
//   cycle_count_o  : cycles since reset
//   drop_count_o   : records lost to a full FIFO
//   overflow_o     : sticky, at least one record dropped
//   done_o         : sticky, halt captured and FIFO drained
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  commit_if.slave          commit_bus,
  trace_if.master          trace_bus,
  output logic [CNT_W-1:0] inst_count_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             overflow_o,
  output logic             done_o
);

  typedef struct packed {
    kind_t             kind;
    logic [CNT_W-1:0]  inum;
    logic [CNT_W-1:0]  cycle;
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] reg_data;
    logic [PC_W-1:0]   addr;
    logic [DATA_W-1:0] mem_data;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  kind_t            kind_s;
  rec_t             rec_s;
  rec_t             head_s;
  logic [REC_W-1:0] fifo_rdata_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             capture_s;
  logic             pop_s;
  logic             push_ok_s;
  logic             drop_s;

  assign capture_s = (state_q == ST_RUN) && commit_bus.commit_valid;
  assign pop_s     = !fifo_empty_s && trace_bus.tr_ready;
  assign push_ok_s = capture_s && (!fifo_full_s || pop_s);
  assign drop_s    = capture_s && fifo_full_s && !pop_s;

  // Classify the commit and build its record; fields unused by a kind stay 0.
  always_comb begin
    kind_s = classify_kind(commit_bus.commit_reg_write, commit_bus.commit_mem_read,
                           commit_bus.commit_mem_write, commit_bus.commit_halt);
    rec_s       = '0;
    rec_s.kind  = kind_s;
    rec_s.inum  = inst_q;
    rec_s.cycle = cycle_q;
    rec_s.pc    = commit_bus.commit_pc;
    case (kind_s)
      KIND_REG: begin
        rec_s.wreg     = commit_bus.commit_write_reg;
        rec_s.reg_data = commit_bus.commit_write_data;
      end
      KIND_LD: begin
        rec_s.wreg     = commit_bus.commit_write_reg;
        rec_s.reg_data = commit_bus.commit_write_data;
        rec_s.addr     = commit_bus.commit_mem_addr;
      end
      KIND_ST: begin
        rec_s.addr     = commit_bus.commit_mem_addr;
        rec_s.mem_data = commit_bus.commit_mem_data;
      end
      KIND_STU: begin
        rec_s.wreg     = commit_bus.commit_write_reg;
        rec_s.reg_data = commit_bus.commit_write_data;
        rec_s.addr     = commit_bus.commit_mem_addr;
        rec_s.mem_data = commit_bus.commit_mem_data;
      end
      default: begin
        rec_s.wreg = '0;
      end
    endcase
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_ok_s),
    .pop_i   (pop_s),
    .wdata_i (rec_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign head_s = fifo_rdata_s;

  // Capture FSM next state: a captured HALT ends capture even if its record
  // was dropped; DRAIN waits for an empty FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (capture_s && (kind_s == KIND_HALT)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Counter and sticky flag next state.
  always_comb begin
    inst_d  = inst_q;
    cycle_d = cycle_q + CNT_W'(1);
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    done_d  = done_q || (state_d == ST_DONE);
    if (capture_s) begin
      inst_d = inst_q + CNT_W'(1);
    end else begin
      inst_d = inst_q;
    end
    if (drop_s) begin
      drop_d = drop_q + CNT_W'(1);
      ovf_d  = 1'b1;
    end else begin
      drop_d = drop_q;
      ovf_d  = ovf_q;
    end
  end

  // State, counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      inst_q  <= '0;
      cycle_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign trace_bus.tr_valid    = !fifo_empty_s;
  assign trace_bus.tr_kind     = head_s.kind;
  assign trace_bus.tr_inum     = head_s.inum;
  assign trace_bus.tr_cycle    = head_s.cycle;
  assign trace_bus.tr_pc       = head_s.pc;
  assign trace_bus.tr_reg      = head_s.wreg;
  assign trace_bus.tr_reg_data = head_s.reg_data;
  assign trace_bus.tr_addr     = head_s.addr;
  assign trace_bus.tr_mem_data = head_s.mem_data;

  assign inst_count_o  = inst_q;
  assign cycle_count_o = cycle_q;
  assign drop_count_o  = drop_q;
  assign overflow_o    = ovf_q;
  assign done_o        = done_q;

endmodule
